// File: rtl/ariane_soc.sv
// Shared SoC definitions for the runtime-programmable address map.
package ariane_soc;

    localparam int unsigned AddrMapNrRules = 16;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        APPLY,
        FAIL
    } addr_map_state_e;

endpackage

// File: rtl/soc_addr_map_pair_chk.sv
// Validates one rule pair: self-check (zero length / wrap past the top of the
// address space) when same=1, otherwise half-open range overlap.
module soc_addr_map_pair_chk #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic                 a_en,
    input  logic [AddrWidth-1:0] a_base,
    input  logic [AddrWidth-1:0] a_len,
    input  logic                 b_en,
    input  logic [AddrWidth-1:0] b_base,
    input  logic [AddrWidth-1:0] b_len,
    input  logic                 same,
    output logic                 err
);

    logic [AddrWidth:0] a_end;
    logic [AddrWidth:0] b_end;
    logic               len_bad;
    logic               overlap;

    // Ends are one bit wider so a rule ending exactly at 2^AddrWidth is legal.
    assign a_end   = {1'b0, a_base} + {1'b0, a_len};
    assign b_end   = {1'b0, b_base} + {1'b0, b_len};
    assign len_bad = (a_len == '0) || (a_end[AddrWidth] && (a_end[AddrWidth-1:0] != '0));
    assign overlap = ({1'b0, a_base} < b_end) && ({1'b0, b_base} < a_end);
    assign err     = same ? (a_en && len_bad) : (a_en && b_en && overlap);

endmodule

// File: rtl/soc_addr_map_table.sv
// Runtime-programmable address map: shadow table, validating commit FSM and
// a one-stage registered lookup against the active table.
module soc_addr_map_table
    import ariane_soc::*;
#(
    parameter int unsigned NrRules    = AddrMapNrRules,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned SlvWidth   = 5,
    parameter int unsigned DefaultSlv = 0,
    localparam int unsigned IdxWidth  = $clog2(NrRules)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_wr_i,
    input  logic [IdxWidth-1:0]  cfg_sel_i,
    input  logic                 cfg_en_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [SlvWidth-1:0]  cfg_slv_i,
    input  logic                 commit_i,
    output logic                 commit_busy_o,
    output logic                 commit_done_o,
    output logic                 commit_err_o,
    output logic [IdxWidth-1:0]  commit_err_rule_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [SlvWidth-1:0]  rsp_slv_o
);

    typedef struct packed {
        logic                 en;
        logic [SlvWidth-1:0]  slv;
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] len;
    } rule_t;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrRules - 1);

    rule_t                shadow_q [NrRules];
    rule_t                active_q [NrRules];
    addr_map_state_e      state_q;
    logic [IdxWidth-1:0]  i_q;
    logic [IdxWidth-1:0]  j_q;

    logic                 a_en;
    logic                 b_en;
    logic [AddrWidth-1:0] a_base;
    logic [AddrWidth-1:0] a_len;
    logic [AddrWidth-1:0] b_base;
    logic [AddrWidth-1:0] b_len;
    logic                 pair_err;
    logic                 dec_hit;
    logic [SlvWidth-1:0]  dec_slv;
    logic                 req_fire;

    assign a_en   = shadow_q[i_q].en;
    assign a_base = shadow_q[i_q].base;
    assign a_len  = shadow_q[i_q].len;
    assign b_en   = shadow_q[j_q].en;
    assign b_base = shadow_q[j_q].base;
    assign b_len  = shadow_q[j_q].len;

    soc_addr_map_pair_chk #(
        .AddrWidth (AddrWidth)
    ) u_pair_chk (
        .a_en   (a_en),
        .a_base (a_base),
        .a_len  (a_len),
        .b_en   (b_en),
        .b_base (b_base),
        .b_len  (b_len),
        .same   (i_q == j_q),
        .err    (pair_err)
    );

    // Commit FSM: scans pairs (i,j), i<=j, row-major, one per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            i_q               <= '0;
            j_q               <= '0;
            commit_err_o      <= 1'b0;
            commit_err_rule_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit_i) begin
                        commit_err_o <= 1'b0;
                        i_q          <= '0;
                        j_q          <= '0;
                        state_q      <= CHECK;
                    end
                end
                CHECK: begin
                    if (pair_err) begin
                        commit_err_o      <= 1'b1;
                        commit_err_rule_o <= i_q;
                        state_q           <= FAIL;
                    end else if ((i_q == LastIdx) && (j_q == LastIdx)) begin
                        state_q <= APPLY;
                    end else if (j_q == LastIdx) begin
                        i_q <= i_q + IdxWidth'(1);
                        j_q <= i_q + IdxWidth'(1);
                    end else begin
                        j_q <= j_q + IdxWidth'(1);
                    end
                end
                APPLY:   state_q <= IDLE;
                FAIL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shadow accepts writes only while idle; active is loaded whole in APPLY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NrRules; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (cfg_wr_i && (state_q == IDLE)) begin
                shadow_q[cfg_sel_i] <= '{en: cfg_en_i, slv: cfg_slv_i,
                                         base: cfg_base_i, len: cfg_len_i};
            end
            if (state_q == APPLY) begin
                for (int k = 0; k < NrRules; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    // Priority decode: scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_slv = SlvWidth'(DefaultSlv);
        for (int k = NrRules - 1; k >= 0; k--) begin
            if (active_q[k].en && (req_addr_i >= active_q[k].base) &&
                ({1'b0, req_addr_i} < ({1'b0, active_q[k].base} + {1'b0, active_q[k].len}))) begin
                dec_hit = 1'b1;
                dec_slv = active_q[k].slv;
            end
        end
    end

    // Blocking requests during APPLY keeps every decode on a complete table.
    assign req_ready_o   = (!rsp_valid_o || rsp_ready_i) && (state_q != APPLY);
    assign req_fire      = req_valid_i && req_ready_o;
    assign commit_busy_o = (state_q != IDLE);
    assign commit_done_o = (state_q == APPLY) || (state_q == FAIL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_slv_o   <= SlvWidth'(DefaultSlv);
        end else if (req_fire) begin
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= dec_hit;
            rsp_slv_o   <= dec_slv;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_soc_addr_map_table.sv
// Self-checking bench for soc_addr_map_table (4 rules): commit scenarios,
// lookup vector table and a response scoreboard.
module tb_soc_addr_map_table;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned SW = 5;

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] slv;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          hit;
        logic [SW-1:0] slv;
    } vec_t;

    logic          clk;
    logic          rst_i;
    logic          cfg_wr_i;
    logic [1:0]    cfg_sel_i;
    logic          cfg_en_i;
    logic [AW-1:0] cfg_base_i;
    logic [AW-1:0] cfg_len_i;
    logic [SW-1:0] cfg_slv_i;
    logic          commit_i;
    logic          commit_busy_o;
    logic          commit_done_o;
    logic          commit_err_o;
    logic [1:0]    commit_err_rule_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          rsp_hit_o;
    logic [SW-1:0] rsp_slv_o;

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    // Bench model of shadow and active tables.
    logic          m_en  [NR];
    logic [AW-1:0] m_base[NR];
    logic [AW-1:0] m_len [NR];
    logic [SW-1:0] m_slv [NR];
    logic          a_en  [NR];
    logic [AW-1:0] a_base[NR];
    logic [AW-1:0] a_len [NR];
    logic [SW-1:0] a_slv [NR];

    vec_t          vecs[7];
    logic [AW-1:0] stream_addr[8];

    soc_addr_map_table #(
        .NrRules    (NR),
        .AddrWidth  (AW),
        .SlvWidth   (SW),
        .DefaultSlv (0)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .cfg_wr_i          (cfg_wr_i),
        .cfg_sel_i         (cfg_sel_i),
        .cfg_en_i          (cfg_en_i),
        .cfg_base_i        (cfg_base_i),
        .cfg_len_i         (cfg_len_i),
        .cfg_slv_i         (cfg_slv_i),
        .commit_i          (commit_i),
        .commit_busy_o     (commit_busy_o),
        .commit_done_o     (commit_done_o),
        .commit_err_o      (commit_err_o),
        .commit_err_rule_o (commit_err_rule_o),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_hit_o         (rsp_hit_o),
        .rsp_slv_o         (rsp_slv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model_decode(input logic [AW-1:0] addr);
        rsp_t r;
        r.hit = 1'b0;
        r.slv = '0;
        for (int k = 0; k < NR; k++) begin
            if (!r.hit && a_en[k] && (addr >= a_base[k]) && ((addr - a_base[k]) < a_len[k])) begin
                r.hit = 1'b1;
                r.slv = a_slv[k];
            end
        end
        return r;
    endfunction

    // Scoreboard: every response handshake pops exactly one expectation.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got hit=%0b slv=%0d required no response", rsp_hit_o, rsp_slv_o);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_hit_o, rsp_slv_o}), 64'({e.hit, e.slv}));
            end
        end
    end

    task automatic clear_model();
        for (int k = 0; k < NR; k++) begin
            m_en[k] = 1'b0; m_base[k] = '0; m_len[k] = '0; m_slv[k] = '0;
            a_en[k] = 1'b0; a_base[k] = '0; a_len[k] = '0; a_slv[k] = '0;
        end
    endtask

    task automatic cfg_write(input int sel, input bit en, input logic [AW-1:0] base,
                             input logic [AW-1:0] len, input logic [SW-1:0] slv, input bit track);
        cfg_wr_i   = 1'b1;
        cfg_sel_i  = 2'(sel);
        cfg_en_i   = en;
        cfg_base_i = base;
        cfg_len_i  = len;
        cfg_slv_i  = slv;
        @(posedge clk); #1;
        cfg_wr_i = 1'b0;
        if (track) begin
            m_en[sel] = en; m_base[sel] = base; m_len[sel] = len; m_slv[sel] = slv;
        end
    endtask

    task automatic do_commit(input bit exp_err, input int exp_rule, input int exp_chk);
        int n;
        int done_cnt;
        n        = 0;
        done_cnt = 0;
        commit_i = 1'b1;
        @(posedge clk); #1;
        commit_i = 1'b0;
        @(negedge clk);
        check("commit_err_cleared", 64'(commit_err_o), 64'(0));
        while (commit_busy_o && n < 200) begin
            if (commit_done_o) begin
                done_cnt++;
                check("done_cycle", 64'(n), 64'(exp_chk));
                if (!exp_err) check("req_ready_in_apply", 64'(req_ready_o), 64'(0));
            end
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(exp_chk + 1));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("commit_err", 64'(commit_err_o), 64'(exp_err));
        if (exp_err) check("commit_err_rule", 64'(commit_err_rule_o), 64'(exp_rule));
        if (!exp_err) begin
            for (int k = 0; k < NR; k++) begin
                a_en[k] = m_en[k]; a_base[k] = m_base[k]; a_len[k] = m_len[k]; a_slv[k] = m_slv[k];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic lookup(input logic [AW-1:0] addr, input bit hit, input logic [SW-1:0] slv);
        int w;
        bit acc;
        w           = 0;
        acc         = 1'b0;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        while (!acc && w < 20) begin
            @(negedge clk);
            if (req_ready_o) begin
                exp_q.push_back(rsp_t'{hit: hit, slv: slv});
                acc = 1'b1;
            end
            @(posedge clk); #1;
            w++;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL lookup_timeout: addr %0h never accepted", addr);
        end else begin
            @(negedge clk);
            check("rsp_latency", 64'(rsp_valid_o), 64'(1));
            @(posedge clk); #1;
        end
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            bit acc;
            w           = 0;
            acc         = 1'b0;
            req_valid_i = 1'b1;
            req_addr_i  = stream_addr[k];
            while (!acc && w < 50) begin
                @(negedge clk);
                if (req_ready_o) begin
                    exp_q.push_back(model_decode(req_addr_i));
                    acc = 1'b1;
                end
                @(posedge clk); #1;
                w++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL stream_timeout: request %0d never accepted", k);
            end
        end
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 64'h9FFF_FFFF,   hit: 1'b1, slv: 5'd15};
        vecs[1] = '{addr: 64'hA000_0000,   hit: 1'b0, slv: 5'd0};
        vecs[2] = '{addr: 64'h1C00_7FFF,   hit: 1'b1, slv: 5'd5};
        vecs[3] = '{addr: 64'h8000_0000,   hit: 1'b1, slv: 5'd15};
        vecs[4] = '{addr: 64'h1BFF_FFFF,   hit: 1'b0, slv: 5'd0};
        vecs[5] = '{addr: 64'h1C00_8000,   hit: 1'b0, slv: 5'd0};
        vecs[6] = '{addr: 64'h7FFF_FFFF,   hit: 1'b0, slv: 5'd0};
        stream_addr[0] = 64'h8000_0000;
        stream_addr[1] = 64'h1C00_0000;
        stream_addr[2] = 64'h0;
        stream_addr[3] = 64'h9FFF_FFFF;
        stream_addr[4] = 64'hA000_0000;
        stream_addr[5] = 64'h1C00_7FFF;
        stream_addr[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        stream_addr[7] = 64'h9000_0000;

        clear_model();
        rst_i = 1'b1; cfg_wr_i = 1'b0; cfg_sel_i = '0; cfg_en_i = 1'b0;
        cfg_base_i = '0; cfg_len_i = '0; cfg_slv_i = '0; commit_i = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // 1: reset state and a miss
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready_o), 64'(1));
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("reset_rsp_hit", 64'(rsp_hit_o), 64'(0));
        check("reset_rsp_slv", 64'(rsp_slv_o), 64'(0));
        check("reset_busy", 64'(commit_busy_o), 64'(0));
        check("reset_done", 64'(commit_done_o), 64'(0));
        @(posedge clk); #1;
        lookup(64'h8000_0000, 1'b0, 5'd0);
        check("reset_commit_err", 64'(commit_err_o), 64'(0));

        // 2: two rules, clean commit, vector table
        cfg_write(0, 1'b1, 64'h8000_0000, 64'h2000_0000, 5'd15, 1'b1);
        cfg_write(1, 1'b1, 64'h1C00_0000, 64'h8000, 5'd5, 1'b1);
        do_commit(1'b0, 0, 10);
        for (int v = 0; v < 7; v++) lookup(vecs[v].addr, vecs[v].hit, vecs[v].slv);

        // 3: overlapping rule2 rejected, active unchanged
        cfg_write(2, 1'b1, 64'h9000_0000, 64'h1000, 5'd3, 1'b1);
        do_commit(1'b1, 0, 3);
        lookup(64'h9000_0000, 1'b1, 5'd15);

        // 4: wrap past the top and zero length on rule3, then legal boundary
        cfg_write(2, 1'b0, 64'h9000_0000, 64'h1000, 5'd3, 1'b1);
        cfg_write(3, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 5'd7, 1'b1);
        do_commit(1'b1, 3, 10);
        cfg_write(3, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 5'd7, 1'b1);
        do_commit(1'b1, 3, 10);
        cfg_write(3, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 5'd7, 1'b1);
        do_commit(1'b0, 0, 10);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd7);
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 5'd0);
        cfg_write(3, 1'b0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 5'd7, 1'b1);
        do_commit(1'b0, 0, 10);

        // 5: write during CHECK dropped; lookup stream with backpressure
        fork
            do_commit(1'b0, 0, 10);
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_write(1, 1'b1, 64'h8000_1000, 64'h10, 5'd9, 1'b0);
            end
            stream(8);
            begin
                for (int c = 0; c < 24; c++) begin
                    @(posedge clk); #1;
                    rsp_ready_i = ~rsp_ready_i;
                end
                rsp_ready_i = 1'b1;
            end
        join
        rsp_ready_i = 1'b1;
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        check("stream_drain", 64'(exp_q.size()), 64'(0));
        do_commit(1'b0, 0, 10);
        lookup(64'h8000_1000, 1'b1, 5'd15);

        // 6: reset in CHECK cycle 5 aborts the commit and clears tables
        commit_i = 1'b1;
        @(posedge clk); #1;
        commit_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("abort_busy", 64'(commit_busy_o), 64'(1));
            check("abort_no_done", 64'(commit_done_o), 64'(0));
        end
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_busy_cleared", 64'(commit_busy_o), 64'(0));
        check("abort_done", 64'(commit_done_o), 64'(0));
        check("abort_err", 64'(commit_err_o), 64'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        clear_model();
        lookup(64'h8000_0000, 1'b0, 5'd0);
        lookup(64'h1C00_0000, 1'b0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_addr_map_table.md
Name: soc_addr_map_table

Overview:
- Runtime-programmable SoC address map; next generation of the fixed compile-time base/length rule table.
- Holds NrRules rules in a shadow table written by a config port.
- A commit FSM validates the shadow rules (zero length, overflow, pairwise overlap) before atomically copying them to the active table.
- A pipelined lookup port decodes addresses against the active table; it sits in front of the crossbar address decoder.

Parameters:
- NrRules, 16, number of rule slots (≥2).
- AddrWidth, 64, address/length width.
- SlvWidth, 5, width of the slave index field.
- DefaultSlv, 0, slave index returned on a miss.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_wr_i  in  1  write one shadow rule.
- cfg_sel_i  in  $clog2(NrRules)  rule slot.
- cfg_en_i  in  1  rule enable.
- cfg_base_i  in  AddrWidth  rule base.
- cfg_len_i  in  AddrWidth  rule length.
- cfg_slv_i  in  SlvWidth  target slave index.
- commit_i  in  1  start validate-and-apply.
- commit_busy_o  out  1  FSM not IDLE.
- commit_done_o  out  1  one-cycle pulse at end of commit.
- commit_err_o  out  1  sticky: last commit rejected.
- commit_err_rule_o  out  $clog2(NrRules)  first offending rule (lower index of the pair).
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  lookup request ready.
- req_addr_i  in  AddrWidth  address to decode.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result accepted.
- rsp_hit_o  out  1  address matched an enabled rule.
- rsp_slv_o  out  SlvWidth  matched slave, or DefaultSlv on a miss.

Behaviour:
- Reset:
  - Both tables cleared (all rules disabled, fields 0); FSM to IDLE.
  - All outputs 0, except req_ready_o=1 and rsp_slv_o=DefaultSlv.
  - Reset mid-commit aborts the commit: no apply, no done pulse.
- Config writes:
  - cfg_wr_i updates shadow[cfg_sel_i] at the clock edge, only when FSM is IDLE.
  - Writes while commit_busy_o=1 are dropped silently.
  - The active table is never written directly.
- Rule range is [base, base+len), computed in AddrWidth+1 bits.
- Commit FSM: IDLE -> CHECK -> (APPLY | FAIL) -> IDLE.
  - IDLE: commit_i=1 clears commit_err_o, loads i=0, j=0, enters CHECK. commit_i in any other state is ignored.
  - CHECK evaluates one pair (i,j), i≤j, per cycle, in row-major order, so a full scan takes NrRules*(NrRules+1)/2 cycles.
  - i==j: error if rule enabled and (len==0 or base+len > 2^AddrWidth).
  - i<j: error if both enabled and b_i < b_j+l_j and b_j < b_i+l_i.
  - Disabled rules never error.
  - First error -> FAIL: sets commit_err_o=1 and commit_err_rule_o=i; active table unchanged.
  - Scan completes with no error -> APPLY: active <= shadow in one cycle.
  - APPLY and FAIL each last 1 cycle, assert commit_done_o, then return to IDLE.
- Lookup:
  - 1-stage registered pipeline.
  - req_ready_o = (!rsp_valid_o | rsp_ready_i) & (state != APPLY).
  - On accept (req_valid_i & req_ready_o), the next cycle presents the decode of req_addr_i against the active table.
  - Lowest enabled matching index wins.
  - Miss -> rsp_hit_o=0, rsp_slv_o=DefaultSlv.
  - rsp_* hold stable while rsp_valid_o & !rsp_ready_i.
  - Back-to-back throughput is 1/cycle when rsp_ready_i=1.
  - Lookups continue during CHECK using the old active table.
  - No lookup is ever decoded against a partially applied table.
- Simultaneous events:
  - cfg_wr_i and commit_i in the same IDLE cycle: the write lands first, then the commit scans the updated shadow.
  - A request accepted in the cycle before APPLY uses the old table.

Decomposition:
- ariane_soc package: commit state enum addr_map_state_e {IDLE, CHECK, APPLY, FAIL}; constant AddrMapNrRules=16.
- Module-local: the rule struct {en, slv, base, len}, since it depends on AddrWidth/SlvWidth.
- Sub-module soc_addr_map_pair_chk: combinational comparator for (rule a, rule b, same) -> err, instantiated once in the CHECK datapath.

Test Plan (NrRules=4, AddrWidth=64, DefaultSlv=0; full scan = 10 CHECK cycles):
1. After reset, lookup 0x8000_0000 -> one cycle later rsp_valid_o=1, rsp_hit_o=0, rsp_slv_o=0; commit_err_o=0.
2. Write rule0 {en, 0x8000_0000, 0x2000_0000, slv 15} and rule1 {en, 0x1C00_0000, 0x8000, slv 5}, then commit -> busy for 10 CHECK + 1 APPLY cycles, done pulse, err=0. Then lookup 0x9FFF_FFFF -> hit, slv 15; 0xA000_0000 -> miss; 0x1C00_7FFF -> slv 5.
3. Add rule2 {en, 0x9000_0000, 0x1000, slv 3}, commit -> FAIL on pair (0,2), commit_err_rule_o=0, err=1; lookup 0x9000_0000 still returns slv 15.
4. Rule3 {en, 0xFFFF_FFFF_FFFF_F000, 0x2000} or any enabled len=0 -> err, commit_err_rule_o=3. Disabling the rule and recommitting clears err.
5. During CHECK: cfg_wr_i to rule1 is dropped (shadow readback via the next commit result is unchanged). Stream 8 lookups with rsp_ready_i toggling 1/0: no loss, no duplication, req_ready_o=0 in the APPLY cycle.
6. Assert rst_i at CHECK cycle 5 -> next cycle busy=0, done never pulses; lookup 0x8000_0000 -> miss (tables cleared).
